// File: rtl/up_dn_counter_param.sv
// Parametrised up/down counter with load, synchronous clear, step size,
// saturate-or-wrap bounds and registered overflow/underflow pulses.
module up_dn_counter_param #(
  parameter int WIDTH   = 5,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int WRAP    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] Step,
  input  logic             Load,
  input  logic             Clear,
  input  logic             Down,
  input  logic             Up,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             Ovf,
  output logic             Unf
);

  localparam int XW = WIDTH + 2;
  localparam logic [WIDTH-1:0]     MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]     MAX_C = WIDTH'(MAX_VAL);
  localparam logic signed [XW-1:0] MIN_X = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X = XW'(MAX_VAL);

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic signed [XW-1:0] sum, dif, inX;

  // Two guard bits keep the sum/difference free of modulo wrap and let the
  // difference go negative, so bound crossings are plain signed compares.
  assign sum = $signed({2'b00, count_q}) + $signed({2'b00, Step});
  assign dif = $signed({2'b00, count_q}) - $signed({2'b00, Step});
  assign inX = $signed({2'b00, IN});

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (Load) begin
      if (inX < MIN_X)      count_d = MIN_C;
      else if (inX > MAX_X) count_d = MAX_C;
      else                  count_d = IN;
    end else if (Clear) begin
      count_d = MIN_C;
    end else if (Down) begin
      if (dif >= MIN_X) begin
        count_d = dif[WIDTH-1:0];
      end else begin
        count_d = (WRAP != 0) ? MAX_C : MIN_C;
        unf_d   = 1'b1;
      end
    end else if (Up) begin
      if (sum <= MAX_X) begin
        count_d = sum[WIDTH-1:0];
      end else begin
        count_d = (WRAP != 0) ? MIN_C : MAX_C;
        ovf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= MIN_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign Counter = count_q;
  assign High    = (count_q == MAX_C);
  assign Low     = (count_q == MIN_C);
  assign Ovf     = ovf_q;
  assign Unf     = unf_q;

endmodule

// File: tb/tb_up_dn_counter_param.sv
// Bench for up_dn_counter_param: three differently configured instances share
// one stimulus stream and are compared every cycle against an integer model.
module tb_up_dn_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] inV, stepV;
  logic       load, clear, down, up;

  logic [4:0] cntO [3];
  logic       highO[3], lowO[3], ovfO[3], unfO[3];

  // Instance configs: 0 = defaults, 1 = [2,20] wrap, 2 = [0,20] saturate
  int minv [3] = '{0, 2, 0};
  int maxv [3] = '{31, 20, 20};
  int wrapv[3] = '{0, 1, 0};

  int mcnt[3];
  int movf[3], munf[3];

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b1;

  int e3c[5] = '{2, 1, 0, 0, 0};
  int e3u[5] = '{0, 0, 0, 1, 1};
  int e3l[5] = '{0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  up_dn_counter_param #(.WIDTH(5)) dut0 (
    .clk(clk), .rst(rst), .IN(inV), .Step(stepV), .Load(load), .Clear(clear),
    .Down(down), .Up(up), .Counter(cntO[0]), .High(highO[0]), .Low(lowO[0]),
    .Ovf(ovfO[0]), .Unf(unfO[0]));

  up_dn_counter_param #(.WIDTH(5), .MIN_VAL(2), .MAX_VAL(20), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .IN(inV), .Step(stepV), .Load(load), .Clear(clear),
    .Down(down), .Up(up), .Counter(cntO[1]), .High(highO[1]), .Low(lowO[1]),
    .Ovf(ovfO[1]), .Unf(unfO[1]));

  up_dn_counter_param #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(20), .WRAP(0)) dut2 (
    .clk(clk), .rst(rst), .IN(inV), .Step(stepV), .Load(load), .Clear(clear),
    .Down(down), .Up(up), .Counter(cntO[2]), .High(highO[2]), .Low(lowO[2]),
    .Ovf(ovfO[2]), .Unf(unfO[2]));

  // Reference model: plain integer arithmetic on the priority rules
  always @(posedge clk or negedge rst) begin
    int t;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mcnt[i] = minv[i];
        movf[i] = 0;
        munf[i] = 0;
      end else begin
        movf[i] = 0;
        munf[i] = 0;
        if (load) begin
          t = int'(inV);
          mcnt[i] = (t < minv[i]) ? minv[i] : ((t > maxv[i]) ? maxv[i] : t);
        end else if (clear) begin
          mcnt[i] = minv[i];
        end else if (down) begin
          t = mcnt[i] - int'(stepV);
          if (t >= minv[i]) mcnt[i] = t;
          else begin
            mcnt[i] = (wrapv[i] != 0) ? maxv[i] : minv[i];
            munf[i] = 1;
          end
        end else if (up) begin
          t = mcnt[i] + int'(stepV);
          if (t <= maxv[i]) mcnt[i] = t;
          else begin
            mcnt[i] = (wrapv[i] != 0) ? minv[i] : maxv[i];
            movf[i] = 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model_cnt%0d", i), int'(cntO[i]), mcnt[i]);
        checkOutput($sformatf("model_high%0d", i), int'(highO[i]), int'(mcnt[i] == maxv[i]));
        checkOutput($sformatf("model_low%0d", i), int'(lowO[i]), int'(mcnt[i] == minv[i]));
        checkOutput($sformatf("model_ovf%0d", i), int'(ovfO[i]), movf[i]);
        checkOutput($sformatf("model_unf%0d", i), int'(unfO[i]), munf[i]);
      end
    end
  end

  task automatic applyStimulus(input bit l, input bit c, input bit d, input bit u,
                               input logic [4:0] inVal, input logic [4:0] st);
    load  = l;
    clear = c;
    down  = d;
    up    = u;
    inV   = inVal;
    stepV = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    load = 0; clear = 0; down = 0; up = 0; inV = '0; stepV = '0;
    @(negedge clk);
    checkOutput("rst_cnt0", int'(cntO[0]), 0);
    checkOutput("rst_low0", int'(lowO[0]), 1);
    checkOutput("rst_high0", int'(highO[0]), 0);
    checkOutput("rst_ovf0", int'(ovfO[0]), 0);
    checkOutput("rst_cnt1", int'(cntO[1]), 2);
    rst = 1'b1;

    // Load beats everything, then Clear beats Down/Up
    applyStimulus(1, 1, 1, 1, 5'd10, 5'd1);
    checkOutput("t2_load0", int'(cntO[0]), 10);
    checkOutput("t2_load1", int'(cntO[1]), 10);
    applyStimulus(0, 1, 1, 1, 5'd10, 5'd1);
    checkOutput("t2_clear0", int'(cntO[0]), 0);
    checkOutput("t2_clear1", int'(cntO[1]), 2);

    // Down into the floor, saturating with repeated Unf
    applyStimulus(1, 0, 0, 0, 5'd3, 5'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 0, 5'd0, 5'd1);
      checkOutput($sformatf("t3_cnt_e%0d", k + 1), int'(cntO[0]), e3c[k]);
      checkOutput($sformatf("t3_unf_e%0d", k + 1), int'(unfO[0]), e3u[k]);
      checkOutput($sformatf("t3_low_e%0d", k + 1), int'(lowO[0]), e3l[k]);
    end

    // Wrap past MAX_VAL on the [2,20] instance
    applyStimulus(1, 0, 0, 0, 5'd18, 5'd0);
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd4);
    checkOutput("t4_cnt1_a", int'(cntO[1]), 2);
    checkOutput("t4_ovf1_a", int'(ovfO[1]), 1);
    checkOutput("t4_cnt0_a", int'(cntO[0]), 22);
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd4);
    checkOutput("t4_cnt1_b", int'(cntO[1]), 6);
    checkOutput("t4_ovf1_b", int'(ovfO[1]), 0);
    checkOutput("t4_cnt0_b", int'(cntO[0]), 26);

    // Up+Down counts down; zero step holds
    applyStimulus(1, 0, 0, 0, 5'd7, 5'd0);
    applyStimulus(0, 0, 1, 1, 5'd0, 5'd2);
    checkOutput("t5_cnt_a", int'(cntO[0]), 5);
    applyStimulus(0, 0, 1, 1, 5'd0, 5'd2);
    checkOutput("t5_cnt_b", int'(cntO[0]), 3);
    applyStimulus(0, 0, 1, 1, 5'd0, 5'd0);
    checkOutput("t5_hold", int'(cntO[0]), 3);
    checkOutput("t5_ovf", int'(ovfO[0]), 0);
    checkOutput("t5_unf", int'(unfO[0]), 0);

    // Load clamp and saturated Up on the [0,20] saturating instance
    applyStimulus(1, 0, 0, 0, 5'd25, 5'd0);
    checkOutput("t6_cnt2", int'(cntO[2]), 20);
    checkOutput("t6_high2", int'(highO[2]), 1);
    checkOutput("t6_cnt0", int'(cntO[0]), 25);
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd1);
    checkOutput("t6_sat_cnt2", int'(cntO[2]), 20);
    checkOutput("t6_sat_ovf2", int'(ovfO[2]), 1);

    // Asynchronous reset in the middle of a cycle
    applyStimulus(1, 0, 0, 0, 5'd9, 5'd0);
    checkOutput("t1_pre", int'(cntO[0]), 9);
    load = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("t1_cnt", int'(cntO[0]), 0);
    checkOutput("t1_low", int'(lowO[0]), 1);
    checkOutput("t1_ovf", int'(ovfO[0]), 0);
    checkOutput("t1_unf", int'(unfO[0]), 0);
    @(negedge clk);
    rst = 1'b1;

    // Randomised traffic, with an occasional reset
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                      5'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 3)));
      end
    end

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
